sys_ctrl_rx: RTL and testbench
==============================

Name: sys_ctrl_rx

Overview:
Receive-side command decoder of the system controller. It sits directly downstream of the UART receiver and its data synchroniser, and consumes one byte per valid pulse. It parses the four command frames (0xAA reg write, 0xBB reg read, 0xCC ALU with operands, 0xDD ALU without operands) and drives the register file and ALU. Read data and ALU results are forwarded to the TX-side controller as a single response pulse.

Parameters:
DATA_W, 8, UART byte width
ADDR_W, 4, register file address width (16 entries)
ALU_OUT_W, 16, ALU result width
FRAME_TMO, 4096, CLK cycles allowed between frames of one command before abort
RSP_TMO, 64, CLK cycles allowed for RdData_VLD/ALU_OUT_VLD before abort

Ports:
CLK  in  1  system clock (REF_CLK domain)
rst_n  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_W  synchronised received byte
RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
RX_ERR  in  1  parity/frame error flag, sampled with RX_D_VLD
WrEn  out  1  register file write strobe
RdEn  out  1  register file read strobe
Address  out  ADDR_W  register file address
WrData  out  DATA_W  register file write data
RdData  in  DATA_W  register file read data
RdData_VLD  in  1  read data valid pulse
ALU_EN  out  1  ALU start strobe
ALU_FUN  out  4  ALU function code
CLK_GATE_EN  out  1  ALU clock-gate enable
ALU_OUT  in  ALU_OUT_W  ALU result
ALU_OUT_VLD  in  1  ALU result valid pulse
RSP_BUSY  in  1  TX controller cannot accept a response
RSP_VLD  out  1  one-cycle response pulse
RSP_DATA  out  ALU_OUT_W  response payload (reads zero-extended)
RSP_TYPE  out  1  0 = register read, 1 = ALU result
CMD_ERR  out  1  one-cycle pulse on any abort

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timers cleared. An asynchronous reset asserted mid-command discards the command; no strobes are issued after reset.
- All strobes (WrEn, RdEn, ALU_EN, RSP_VLD, CMD_ERR) are registered and last exactly one cycle. Address, WrData and ALU_FUN hold their values until the next update.
- A byte with RX_ERR=1 in any state aborts to IDLE with CMD_ERR.
- IDLE: on RX_D_VLD, 0xAA→WR_ADDR, 0xBB→RD_ADDR, 0xCC→ALU_A, 0xDD→ALU_FUN. Any other byte: CMD_ERR, stay in IDLE.
- WR_ADDR: on a byte, if bits [7:ADDR_W] are non-zero, abort; otherwise latch Address and go to WR_DATA.
- WR_DATA: on a byte, WrData=byte and WrEn pulses the next cycle; go to IDLE.
- RD_ADDR: range-check the byte as in WR_ADDR, latch Address, go to RD_ISSUE.
- ALU_A: write the byte to address 0 (WrEn pulse), go to ALU_B.
- ALU_B: write the byte to address 1 (WrEn pulse), go to ALU_FUN.
- ALU_FUN: latch ALU_FUN=byte[3:0] and set CLK_GATE_EN=1; go to ALU_ISSUE.
- RD_ISSUE / ALU_ISSUE: wait while RSP_BUSY=1 (no timeout). Then pulse RdEn or ALU_EN and go to RD_WAIT or ALU_WAIT.
- RD_WAIT: on RdData_VLD, RSP_DATA={0,RdData}, RSP_TYPE=0, RSP_VLD pulses; go to IDLE.
- ALU_WAIT: on ALU_OUT_VLD, RSP_DATA=ALU_OUT, RSP_TYPE=1, RSP_VLD pulses, CLK_GATE_EN=0; go to IDLE.
- Frame timer: reloads on every RX_D_VLD and runs in the WR_*, RD_ADDR and ALU_A/B/FUN states. When it expires, abort.
- Response timer: runs in RD_WAIT and ALU_WAIT. When it expires, abort.
- Any abort clears CLK_GATE_EN and pulses CMD_ERR.
- RX_D_VLD in the ISSUE or WAIT states: byte dropped, CMD_ERR pulsed, FSM unaffected.
- WrEn and RX_D_VLD arriving in the same cycle: the strobe still issues and the new byte is processed normally. The minimum byte spacing is far larger than one cycle.

Decomposition:
- Shared package (sys_ctrl_pkg): command opcodes (CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD), operand addresses (OPA_ADDR=0, OPB_ADDR=1), and the FSM state encoding.
- One sub-module: sys_ctrl_tmr, a loadable down-counter with an expire pulse. It is instantiated twice: frame timeout and response timeout.

Test Plan:
- Write: bytes AA,05,3C → one WrEn with Address=5, WrData=3C; no CMD_ERR.
- Read: AA,07,5A then BB,07; reg file returns 5A → RdEn at Address=7, then RSP_VLD with RSP_DATA=005A, RSP_TYPE=0.
- ALU with operands: CC,0A,03,00 → WrEn addr0=0A, WrEn addr1=03, ALU_EN with ALU_FUN=0. ALU_OUT=000D returns → RSP_VLD, RSP_TYPE=1, CLK_GATE_EN drops.
- Backpressure: DD,02 with RSP_BUSY=1 for 100 cycles → ALU_EN is issued only after RSP_BUSY falls, and no timeout fires.
- Errors: command 0x55 → CMD_ERR, FSM stays in IDLE. AA then address 0x15 → CMD_ERR, no WrEn. BB,03 with no RdData_VLD → CMD_ERR after RSP_TMO cycles.
- Aborts: AA,04 then silence for FRAME_TMO cycles → CMD_ERR, and a subsequent AA,04,11 completes correctly. rst_n pulsed between CC and its operand A → no WrEn afterwards.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-controller receive path: command opcodes,
// operand register addresses, FSM state encoding and state-group helpers.
// No logic, no latency, no backpressure.
package sys_ctrl_pkg;

    // Command opcodes (first byte of every command)
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register file slots that hold the ALU operands
    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN,
        ST_ALU_ISSUE,
        ST_ALU_WAIT
    } state_t;

    // States in which the FSM is waiting for the next byte of a command
    function automatic logic in_frame(input state_t s);
        return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                         ST_ALU_A, ST_ALU_B, ST_ALU_FUN};
    endfunction

    // States in which the FSM is waiting for read data or an ALU result
    function automatic logic in_rsp_wait(input state_t s);
        return s inside {ST_RD_WAIT, ST_ALU_WAIT};
    endfunction

endpackage

// File: rtl/sys_ctrl_tmr.sv
// Loadable down-counter raising a one-cycle expire after TMO running cycles.
// Latency: expire is combinational from the count; load has priority over run.
// Backpressure: none; run simply pauses the count when low.
// Ports: CLK, rst_n       clock and async active-low reset (count cleared)
//        load            reload the count to TMO (suppresses expire)
//        run             decrement while non-zero
//        expire          high in the TMO-th running cycle after a load
module sys_ctrl_tmr #(
    parameter int unsigned TMO = 64
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TMO + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TMO);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Fires on the cycle the count would reach zero; stays quiet at zero so
    // a stalled counter cannot fire twice.
    assign expire = run && !load && (cnt == CW'(1));

endmodule

// File: rtl/sys_ctrl_rx.sv
// Receive-side command decoder: parses UART command frames into register-file
// and ALU strobes and forwards read data / ALU results as one response pulse.
// Latency: every strobe is registered, one cycle after the triggering input.
// Backpressure: RSP_BUSY holds the FSM in the ISSUE states (untimed); no input stall.
// Ports: CLK/rst_n clock + async reset; RX_P_DATA/RX_D_VLD/RX_ERR received bytes;
//        WrEn/RdEn/Address/WrData/RdData/RdData_VLD register file side;
//        ALU_EN/ALU_FUN/CLK_GATE_EN/ALU_OUT/ALU_OUT_VLD ALU side;
//        RSP_BUSY/RSP_VLD/RSP_DATA/RSP_TYPE response to TX controller; CMD_ERR abort pulse.
module sys_ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ALU_OUT_W = 16,
    parameter int unsigned FRAME_TMO = 4096,
    parameter int unsigned RSP_TMO   = 64
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    RX_P_DATA,
    input  logic                 RX_D_VLD,
    input  logic                 RX_ERR,
    output logic                 WrEn,
    output logic                 RdEn,
    output logic [ADDR_W-1:0]    Address,
    output logic [DATA_W-1:0]    WrData,
    input  logic [DATA_W-1:0]    RdData,
    input  logic                 RdData_VLD,
    output logic                 ALU_EN,
    output logic [3:0]           ALU_FUN,
    output logic                 CLK_GATE_EN,
    input  logic [ALU_OUT_W-1:0] ALU_OUT,
    input  logic                 ALU_OUT_VLD,
    input  logic                 RSP_BUSY,
    output logic                 RSP_VLD,
    output logic [ALU_OUT_W-1:0] RSP_DATA,
    output logic                 RSP_TYPE,
    output logic                 CMD_ERR
);

    state_t state;
    logic   frm_exp;
    logic   rsp_exp;
    logic   addr_bad;
    logic   abort;

    // Frame timer restarts on every byte and idles outside frame states.
    sys_ctrl_tmr #(.TMO(FRAME_TMO)) u_frm_tmr (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .load   (RX_D_VLD || !in_frame(state)),
        .run    (in_frame(state)),
        .expire (frm_exp)
    );

    // Response timer only counts while a read/ALU result is outstanding.
    sys_ctrl_tmr #(.TMO(RSP_TMO)) u_rsp_tmr (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .load   (!in_rsp_wait(state)),
        .run    (in_rsp_wait(state)),
        .expire (rsp_exp)
    );

    // An address byte must fit the register file; any upper bit set is illegal.
    assign addr_bad = |RX_P_DATA[DATA_W-1:ADDR_W];

    // All abort causes in one place. A result arriving on the timeout cycle
    // wins over the timeout.
    always_comb begin
        abort = 1'b0;
        if (RX_D_VLD && RX_ERR) begin
            abort = 1'b1;
        end else begin
            case (state)
                ST_WR_ADDR, ST_RD_ADDR:
                    abort = RX_D_VLD ? addr_bad : frm_exp;
                ST_WR_DATA, ST_ALU_A, ST_ALU_B, ST_ALU_FUN:
                    abort = frm_exp;
                ST_RD_WAIT:
                    abort = rsp_exp && !RdData_VLD;
                ST_ALU_WAIT:
                    abort = rsp_exp && !ALU_OUT_VLD;
                default:
                    abort = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            RSP_VLD     <= 1'b0;
            RSP_DATA    <= '0;
            RSP_TYPE    <= 1'b0;
            CMD_ERR     <= 1'b0;
        end else begin
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            ALU_EN  <= 1'b0;
            RSP_VLD <= 1'b0;
            CMD_ERR <= 1'b0;

            if (abort) begin
                state       <= ST_IDLE;
                CLK_GATE_EN <= 1'b0;
                CMD_ERR     <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (RX_D_VLD) begin
                            case (RX_P_DATA)
                                CMD_WR:      state <= ST_WR_ADDR;
                                CMD_RD:      state <= ST_RD_ADDR;
                                CMD_ALU_OP:  state <= ST_ALU_A;
                                CMD_ALU_NOP: state <= ST_ALU_FUN;
                                default:     CMD_ERR <= 1'b1;
                            endcase
                        end
                    end
                    ST_WR_ADDR: begin
                        if (RX_D_VLD) begin
                            Address <= RX_P_DATA[ADDR_W-1:0];
                            state   <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        if (RX_D_VLD) begin
                            WrData <= RX_P_DATA;
                            WrEn   <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (RX_D_VLD) begin
                            Address <= RX_P_DATA[ADDR_W-1:0];
                            state   <= ST_RD_ISSUE;
                        end
                    end
                    ST_ALU_A: begin
                        if (RX_D_VLD) begin
                            Address <= ADDR_W'(OPA_ADDR);
                            WrData  <= RX_P_DATA;
                            WrEn    <= 1'b1;
                            state   <= ST_ALU_B;
                        end
                    end
                    ST_ALU_B: begin
                        if (RX_D_VLD) begin
                            Address <= ADDR_W'(OPB_ADDR);
                            WrData  <= RX_P_DATA;
                            WrEn    <= 1'b1;
                            state   <= ST_ALU_FUN;
                        end
                    end
                    ST_ALU_FUN: begin
                        if (RX_D_VLD) begin
                            ALU_FUN     <= RX_P_DATA[3:0];
                            CLK_GATE_EN <= 1'b1;
                            state       <= ST_ALU_ISSUE;
                        end
                    end
                    // In ISSUE/WAIT a stray byte is dropped and flagged, but the
                    // command in flight carries on.
                    ST_RD_ISSUE: begin
                        if (RX_D_VLD) CMD_ERR <= 1'b1;
                        if (!RSP_BUSY) begin
                            RdEn  <= 1'b1;
                            state <= ST_RD_WAIT;
                        end
                    end
                    ST_ALU_ISSUE: begin
                        if (RX_D_VLD) CMD_ERR <= 1'b1;
                        if (!RSP_BUSY) begin
                            ALU_EN <= 1'b1;
                            state  <= ST_ALU_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (RX_D_VLD) CMD_ERR <= 1'b1;
                        if (RdData_VLD) begin
                            RSP_DATA <= ALU_OUT_W'(RdData);
                            RSP_TYPE <= 1'b0;
                            RSP_VLD  <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_ALU_WAIT: begin
                        if (RX_D_VLD) CMD_ERR <= 1'b1;
                        if (ALU_OUT_VLD) begin
                            RSP_DATA    <= ALU_OUT;
                            RSP_TYPE    <= 1'b1;
                            RSP_VLD     <= 1'b1;
                            CLK_GATE_EN <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Bench for sys_ctrl_rx: command-level reference model feeds per-strobe
// expectation queues; an independent monitor pops and compares on every strobe.
// Register file and ALU are emulated by the bench with random response delays.
module tb_sys_ctrl_rx;

    localparam int FT = 4096;
    localparam int RT = 64;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD, RX_ERR;
    logic        WrEn, RdEn;
    logic [3:0]  Address;
    logic [7:0]  WrData, RdData;
    logic        RdData_VLD, ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD, RSP_BUSY, RSP_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_TYPE, CMD_ERR;

    sys_ctrl_rx dut (
        .CLK(CLK), .rst_n(rst_n),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_VLD(RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .RSP_BUSY(RSP_BUSY), .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA),
        .RSP_TYPE(RSP_TYPE), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic busy_q = 1'b0;
    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        busy_q <= RSP_BUSY;
    end

    // Expectation queues
    logic [11:0] wr_q[$];   // {addr, data}
    logic [3:0]  rd_q[$];
    logic [3:0]  alu_q[$];
    logic [16:0] rsp_q[$];  // {type, data}
    int          err_lo[$], err_hi[$];

    logic [7:0] mregs[16];     // model view of the register file
    logic [7:0] env_regs[16];  // emulated register file, written by the DUT
    bit         env_silent = 0;
    bit         busy_force = 0;
    bit         busy_rand  = 0;
    int         last_t;

    function automatic logic [15:0] alu_f(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd0: return 16'(a) + 16'(b);
            4'd1: return 16'(a) - 16'(b);
            4'd2: return 16'(a) * 16'(b);
            4'd3: return 16'(a & b);
            4'd4: return 16'(a | b);
            4'd5: return 16'(a ^ b);
            default: return {a, b};
        endcase
    endfunction

    function automatic int pending();
        return wr_q.size() + rd_q.size() + alu_q.size() + rsp_q.size() + err_lo.size();
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (rst_n) begin
            if (WrEn) begin
                chk(wr_q.size() > 0, "wr_present", wr_q.size(), 1);
                if (wr_q.size() > 0) begin
                    logic [11:0] e;
                    e = wr_q.pop_front();
                    chk({Address, WrData} === e, "wr_addr_data", {Address, WrData}, e);
                end
            end
            if (RdEn) begin
                chk(rd_q.size() > 0, "rd_present", rd_q.size(), 1);
                chk(busy_q == 1'b0, "rd_while_busy", busy_q, 0);
                if (rd_q.size() > 0) begin
                    logic [3:0] e;
                    e = rd_q.pop_front();
                    chk(Address === e, "rd_addr", Address, e);
                end
            end
            if (ALU_EN) begin
                chk(alu_q.size() > 0, "alu_present", alu_q.size(), 1);
                chk(busy_q == 1'b0, "alu_while_busy", busy_q, 0);
                chk(CLK_GATE_EN === 1'b1, "gate_on_at_alu_en", CLK_GATE_EN, 1);
                if (alu_q.size() > 0) begin
                    logic [3:0] e;
                    e = alu_q.pop_front();
                    chk(ALU_FUN === e, "alu_fun", ALU_FUN, e);
                end
            end
            if (RSP_VLD) begin
                chk(rsp_q.size() > 0, "rsp_present", rsp_q.size(), 1);
                if (rsp_q.size() > 0) begin
                    logic [16:0] e;
                    e = rsp_q.pop_front();
                    chk({RSP_TYPE, RSP_DATA} === e, "rsp_type_data", {RSP_TYPE, RSP_DATA}, e);
                    if (e[16]) chk(CLK_GATE_EN === 1'b0, "gate_off_after_alu", CLK_GATE_EN, 0);
                end
            end
            if (CMD_ERR) begin
                chk(err_lo.size() > 0, "err_present", err_lo.size(), 1);
                if (err_lo.size() > 0) begin
                    int lo, hi;
                    lo = err_lo.pop_front();
                    hi = err_hi.pop_front();
                    chk(cyc >= lo && cyc <= hi, "err_timing", cyc, lo);
                end
            end
        end
    end

    // Emulated register file and ALU
    initial begin
        int rd_left, alu_left;
        logic [3:0] rd_a, alu_fn;
        rd_left = 0; alu_left = 0; rd_a = 0; alu_fn = 0;
        RdData = '0; RdData_VLD = 0; ALU_OUT = '0; ALU_OUT_VLD = 0;
        forever begin
            @(negedge CLK);
            RdData_VLD  = 0;
            ALU_OUT_VLD = 0;
            if (!rst_n) begin
                rd_left = 0; alu_left = 0;
            end else begin
                if (WrEn) env_regs[Address] = WrData;
                if (RdEn && !env_silent) begin rd_left = int'($urandom_range(1, 5)); rd_a = Address; end
                if (ALU_EN && !env_silent) begin alu_left = int'($urandom_range(1, 8)); alu_fn = ALU_FUN; end
                if (rd_left > 0) begin
                    rd_left--;
                    if (rd_left == 0) begin RdData = env_regs[rd_a]; RdData_VLD = 1; end
                end
                if (alu_left > 0) begin
                    alu_left--;
                    if (alu_left == 0) begin ALU_OUT = alu_f(alu_fn, env_regs[0], env_regs[1]); ALU_OUT_VLD = 1; end
                end
            end
        end
    end

    // TX-side busy emulation
    initial begin
        RSP_BUSY = 0;
        forever begin
            @(negedge CLK);
            RSP_BUSY = busy_force || (busy_rand && ($urandom_range(0, 2) == 0));
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit err, input bit exp_err);
        @(negedge CLK);
        RX_P_DATA = b; RX_D_VLD = 1; RX_ERR = err;
        last_t = cyc;
        if (exp_err) begin err_lo.push_back(last_t + 1); err_hi.push_back(last_t + 2); end
        @(negedge CLK);
        RX_D_VLD = 0; RX_ERR = 0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
        send_byte(8'hAA, 0, 0);
        if (a[7:4] != 0) begin
            send_byte(a, 0, 1);
        end else begin
            send_byte(a, 0, 0);
            wr_q.push_back({a[3:0], d});
            mregs[a[3:0]] = d;
            send_byte(d, 0, 0);
        end
    endtask

    task automatic cmd_read(input logic [7:0] a, input bit silent);
        send_byte(8'hBB, 0, 0);
        if (a[7:4] != 0) begin
            send_byte(a, 0, 1);
        end else begin
            rd_q.push_back(a[3:0]);
            if (!silent) rsp_q.push_back({1'b0, 8'h00, mregs[a[3:0]]});
            send_byte(a, 0, 0);
            if (silent) begin err_lo.push_back(last_t + RT); err_hi.push_back(last_t + RT + 6); end
        end
    endtask

    task automatic cmd_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        if (with_ops) begin
            send_byte(8'hCC, 0, 0);
            wr_q.push_back({4'd0, a}); mregs[0] = a;
            send_byte(a, 0, 0);
            wr_q.push_back({4'd1, b}); mregs[1] = b;
            send_byte(b, 0, 0);
        end else begin
            send_byte(8'hDD, 0, 0);
        end
        alu_q.push_back(f[3:0]);
        rsp_q.push_back({1'b1, alu_f(f[3:0], mregs[0], mregs[1])});
        send_byte(f, 0, 0);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && pending() != 0; i++) @(negedge CLK);
        chk(pending() == 0, "drain", pending(), 0);
        wr_q.delete(); rd_q.delete(); alu_q.delete(); rsp_q.delete();
        err_lo.delete(); err_hi.delete();
        repeat (4) @(negedge CLK);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({WrEn, RdEn, ALU_EN, RSP_VLD, CMD_ERR, CLK_GATE_EN} == 6'b0, name,
            {WrEn, RdEn, ALU_EN, RSP_VLD, CMD_ERR, CLK_GATE_EN}, 0);
        chk({Address, WrData, ALU_FUN, RSP_DATA, RSP_TYPE} == '0, {name, "_data"},
            {Address, WrData, ALU_FUN, RSP_DATA, RSP_TYPE}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin mregs[i] = 8'h00; env_regs[i] = 8'h00; end
        rst_n = 0; RX_P_DATA = 0; RX_D_VLD = 0; RX_ERR = 0;
        repeat (3) @(negedge CLK);
        chk_outputs_zero("reset_active");
        rst_n = 1;
        @(negedge CLK);
        chk_outputs_zero("reset_released");

        // Basic write, write-then-read, ALU with operands
        cmd_write(8'h05, 8'h3C);          wait_drain(200);
        cmd_write(8'h07, 8'h5A);          wait_drain(200);
        cmd_read(8'h07, 0);               wait_drain(200);
        cmd_alu(1, 8'h0A, 8'h03, 8'h00);  wait_drain(200);

        // Backpressure: ALU_EN must wait for RSP_BUSY to fall, no timeout
        busy_force = 1;
        cmd_alu(0, 8'h00, 8'h00, 8'h02);
        repeat (100) @(negedge CLK);
        chk(alu_q.size() == 1, "alu_held_by_busy", alu_q.size(), 1);
        busy_force = 0;
        wait_drain(200);

        // Errors: bad opcode, bad address, missing read data
        send_byte(8'h55, 0, 1);           wait_drain(50);
        cmd_write(8'h15, 8'h77);          wait_drain(50);
        env_silent = 1;
        cmd_read(8'h03, 1);               wait_drain(300);
        env_silent = 0;

        // Frame timeout, then a clean write
        send_byte(8'hAA, 0, 0);
        send_byte(8'h04, 0, 0);
        err_lo.push_back(last_t + FT - 2); err_hi.push_back(last_t + FT + 4);
        wait_drain(FT + 200);
        cmd_write(8'h04, 8'h11);          wait_drain(200);

        // Reset between ALU opcode and operand A discards the command
        send_byte(8'hCC, 0, 0);
        rst_n = 0;
        repeat (2) @(negedge CLK);
        chk_outputs_zero("reset_mid_cmd");
        rst_n = 1;
        @(negedge CLK);
        send_byte(8'h0A, 0, 1);           wait_drain(50);

        // Randomised command mix
        for (int n = 0; n < 40; n++) begin
            int kind;
            busy_rand = ($urandom_range(0, 1) == 1);
            kind = int'($urandom_range(0, 7));
            case (kind)
                0: cmd_write(8'($urandom_range(0, 15)), 8'($urandom));
                1, 7: cmd_read(8'($urandom_range(0, 15)), 0);
                2: cmd_alu(1, 8'($urandom), 8'($urandom), 8'($urandom));
                3: cmd_alu(0, 8'h00, 8'h00, 8'($urandom));
                4: begin
                    do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
                    send_byte(b, 0, 1);
                end
                5: if ($urandom_range(0, 1) == 1) cmd_write(8'($urandom_range(16, 255)), 8'($urandom));
                   else cmd_read(8'($urandom_range(16, 255)), 0);
                default: begin
                    case ($urandom_range(0, 2))
                        0: ;
                        1: send_byte(8'hAA, 0, 0);
                        default: begin
                            send_byte(8'hCC, 0, 0);
                            b = 8'($urandom);
                            wr_q.push_back({4'd0, b}); mregs[0] = b;
                            send_byte(b, 0, 0);
                        end
                    endcase
                    send_byte(8'($urandom), 1, 1);
                end
            endcase
            wait_drain(300);
            busy_rand = 0;
        end

        repeat (50) @(negedge CLK);
        chk(pending() == 0, "final_idle", pending(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
